// File: rtl/vc_fifo_pop_mux.sv
`default_nettype none
// ============================================================================
//  Module   : vc_fifo_pop_mux
//  Purpose  : Pop/forward stage between NUM_CH virtual-channel FIFOs and the
//             principal FIFO. Qualifies the arbiter's one-hot grant against
//             empty flags and principal-FIFO backpressure, pops the granted
//             VC FIFO, and pushes the word two cycles later with its source
//             channel tag.
//  Ports    : clock, reset        - clock (posedge), synchronous active-high reset
//             pop_req, grand      - move request and one-hot arbiter grant
//             empty, data_in      - per-VC empty flags and read data
//             almost_full         - principal FIFO has <=2 free slots
//             pop                 - one-hot pop strobe to the VC FIFOs
//             push, data_out      - push strobe and word to the principal FIFO
//             src_id              - channel index of data_out
//             busy                - a word is in flight
//             err_grand           - sticky: request seen with non-one-hot grant
//             cnt_sel, cnt_out    - per-channel pop counter readout
//                                   (present only with VC_POP_CNT_EN)
//  Options  : define VC_POP_CNT_EN to add saturating per-channel pop counters
//  Revision : 1.0 - initial release
// ============================================================================
module vc_fifo_pop_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4
`ifdef VC_POP_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pop_req,
    input  logic [NUM_CH-1:0]         grand,
    input  logic [NUM_CH-1:0]         empty,
    input  logic [NUM_CH*DATA_W-1:0]  data_in,
    input  logic                      almost_full,
    output logic [NUM_CH-1:0]         pop,
    output logic                      push,
    output logic [DATA_W-1:0]         data_out,
    output logic [$clog2(NUM_CH)-1:0] src_id,
    output logic                      busy,
    output logic                      err_grand
`ifdef VC_POP_CNT_EN
    ,
    input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
    output logic [CNT_W-1:0]          cnt_out
`endif
);

    localparam int IDX_W = $clog2(NUM_CH);

    logic              w_onehot;
    logic              w_go;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_s1_valid;
    logic [IDX_W-1:0]  r_s1_idx;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_src;
    logic              r_err;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_onehot = (grand != '0) && ((grand & (grand - NUM_CH'(1))) == '0);

    // reset is included so pop is forced low combinationally during reset.
    assign w_go = pop_req & w_onehot & ~|(grand & empty) & ~almost_full & ~reset;

    assign pop = w_go ? grand : '0;

    // Grant to index encoder; only meaningful when the grant is one-hot.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grand[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // VC FIFO read data appears the cycle after the pop, so select it with
    // the registered stage-1 index.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_s1_idx == IDX_W'(i)) begin
                w_sel_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_data     <= '0;
            r_src      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_go;
            if (w_go) begin
                r_s1_idx <= w_idx;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data <= w_sel_data;
                r_src  <= r_s1_idx;
            end
            // Sticky regardless of backpressure in the same cycle.
            if (pop_req && !w_onehot) begin
                r_err <= 1'b1;
            end
        end
    end

    assign push      = r_s2_valid;
    assign data_out  = r_data;
    assign src_id    = r_src;
    assign busy      = r_s1_valid | r_s2_valid;
    assign err_grand = r_err;

`ifdef VC_POP_CNT_EN
    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [CNT_W-1:0] w_cnt_sel;
    logic [CNT_W-1:0] r_cnt_out;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_cnt
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt[g] <= '0;
                end else if (pop[g] && (r_cnt[g] != '1)) begin
                    r_cnt[g] <= r_cnt[g] + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_sel == IDX_W'(i)) begin
                w_cnt_sel = r_cnt[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt_out <= '0;
        end else begin
            r_cnt_out <= w_cnt_sel;
        end
    end

    assign cnt_out = r_cnt_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo_pop_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vc_fifo_pop_mux
//  Purpose  : Self-checking bench for vc_fifo_pop_mux (NUM_CH=4, DATA_W=4).
//             Table of per-cycle inputs and hand-computed outputs, plus
//             directed sequences for backpressure, reset and counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vc_fifo_pop_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        pop_req;
    logic [3:0]  grand;
    logic [3:0]  empty;
    logic [15:0] data_in;
    logic        almost_full;
    logic [3:0]  pop;
    logic        push;
    logic [3:0]  data_out;
    logic [1:0]  src_id;
    logic        busy;
    logic        err_grand;
`ifdef VC_POP_CNT_EN
    logic [1:0]  cnt_sel;
    logic [1:0]  cnt_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vc_fifo_pop_mux #(
        .NUM_CH (4),
        .DATA_W (4)
`ifdef VC_POP_CNT_EN
        ,
        .CNT_W  (2)
`endif
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .pop_req     (pop_req),
        .grand       (grand),
        .empty       (empty),
        .data_in     (data_in),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .src_id      (src_id),
        .busy        (busy),
        .err_grand   (err_grand)
`ifdef VC_POP_CNT_EN
        ,
        .cnt_sel     (cnt_sel),
        .cnt_out     (cnt_out)
`endif
    );

    typedef struct {
        logic       req;
        logic [3:0] g;
        logic [3:0] e;
        logic       af;
        logic [3:0] exp_pop;
        logic       exp_push;
        logic [3:0] exp_dout;
        logic [1:0] exp_src;
        logic       exp_busy;
        logic       exp_err;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; leave the bench 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // data_in ch3..ch0 = 4,3,2,1 throughout the table
        //          req g        e        af   pop      push dout  src   busy err
        tbl[0]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'h0, 2'd0, 0, 0};
        tbl[1]  = '{1, 4'b0001, 4'b0000, 0, 4'b0001, 0, 4'h0, 2'd0, 0, 0};
        tbl[2]  = '{1, 4'b0010, 4'b0000, 0, 4'b0010, 0, 4'h0, 2'd0, 1, 0};
        tbl[3]  = '{1, 4'b0100, 4'b0000, 0, 4'b0100, 1, 4'h1, 2'd0, 1, 0};
        tbl[4]  = '{1, 4'b1000, 4'b0000, 0, 4'b1000, 1, 4'h2, 2'd1, 1, 0};
        tbl[5]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 4'h3, 2'd2, 1, 0};
        tbl[6]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 4'h4, 2'd3, 1, 0};
        tbl[7]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'h4, 2'd3, 0, 0};
        tbl[8]  = '{1, 4'b0100, 4'b0100, 0, 4'b0000, 0, 4'h4, 2'd3, 0, 0};
        tbl[9]  = '{1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 4'h4, 2'd3, 0, 0};
        tbl[10] = '{1, 4'b0001, 4'b1110, 0, 4'b0001, 0, 4'h4, 2'd3, 0, 0};
        tbl[11] = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'h4, 2'd3, 1, 0};
        tbl[12] = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 4'h1, 2'd0, 1, 0};
        tbl[13] = '{1, 4'b0110, 4'b0000, 0, 4'b0000, 0, 4'h1, 2'd0, 0, 0};
        tbl[14] = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'h1, 2'd0, 0, 1};
        tbl[15] = '{1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'h1, 2'd0, 0, 1};
        tbl[16] = '{1, 4'b1000, 4'b0000, 0, 4'b1000, 0, 4'h1, 2'd0, 0, 1};
        tbl[17] = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'h1, 2'd0, 1, 1};
        tbl[18] = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 4'h4, 2'd3, 1, 1};

        reset       = 1'b1;
        pop_req     = 1'b1;
        grand       = 4'b0001;
        empty       = 4'b0000;
        data_in     = 16'h4321;
        almost_full = 1'b0;
`ifdef VC_POP_CNT_EN
        cnt_sel     = 2'd0;
`endif
        step();
        step();

        // Reset state; pop must be gated by reset even with a valid request.
        chk("rst_pop",  32'(pop), 32'h0);
        chk("rst_push", 32'(push), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_src",  32'(src_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err",  32'(err_grand), 32'h0);

        reset   = 1'b0;
        pop_req = 1'b0;
        grand   = 4'b0000;

        // Table-driven per-cycle vectors.
        for (int i = 0; i < 19; i++) begin
            pop_req     = tbl[i].req;
            grand       = tbl[i].g;
            empty       = tbl[i].e;
            almost_full = tbl[i].af;
            #1;
            chk($sformatf("v%0d_pop", i),  32'(pop), 32'(tbl[i].exp_pop));
            chk($sformatf("v%0d_push", i), 32'(push), 32'(tbl[i].exp_push));
            chk($sformatf("v%0d_dout", i), 32'(data_out), 32'(tbl[i].exp_dout));
            chk($sformatf("v%0d_src", i),  32'(src_id), 32'(tbl[i].exp_src));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            chk($sformatf("v%0d_err", i),  32'(err_grand), 32'(tbl[i].exp_err));
            step();
        end
        pop_req = 1'b0;
        grand   = 4'b0000;
        empty   = 4'b0000;

        // Backpressure: stream on ch0, almost_full rises at W3.
        pop_req = 1'b1;
        grand   = 4'b0001;
        step();                              // W0 popped
        step();                              // W1 popped
        step();                              // W2 popped
        almost_full = 1'b1;
        #1;
        chk("bp_pop_blocked", 32'(pop), 32'h0);
        chk("bp_push_a", 32'(push), 32'h1);
        step();
        chk("bp_pop_blocked2", 32'(pop), 32'h0);
        chk("bp_push_b", 32'(push), 32'h1);
        step();
        chk("bp_push_stop", 32'(push), 32'h0);
        step();
        chk("bp_idle_busy", 32'(busy), 32'h0);
        chk("bp_idle_push", 32'(push), 32'h0);
        almost_full = 1'b0;
        #1;
        chk("bp_resume_pop", 32'(pop), 32'h1);
        step();
        pop_req = 1'b0;
        grand   = 4'b0000;
        step();
        chk("bp_resume_push", 32'(push), 32'h1);
        chk("bp_resume_dout", 32'(data_out), 32'h1);
        step();
        step();

        // Reset mid-operation: pop at W, reset at W+1, no push afterwards.
        pop_req = 1'b1;
        grand   = 4'b0010;
        #1;
        chk("mr_pop", 32'(pop), 32'h2);
        step();
        reset = 1'b1;
        #1;
        chk("mr_pop_gated", 32'(pop), 32'h0);
        chk("mr_busy_pre", 32'(busy), 32'h1);
        step();
        reset   = 1'b0;
        pop_req = 1'b0;
        grand   = 4'b0000;
        chk("mr_push", 32'(push), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_dout", 32'(data_out), 32'h0);
        chk("mr_err_cleared", 32'(err_grand), 32'h0);
        step();
        chk("mr_push_late", 32'(push), 32'h0);

        // Single pop on ch1 carrying 4'hA.
        data_in = 16'h00A0;
        pop_req = 1'b1;
        grand   = 4'b0010;
        #1;
        chk("s1_pop", 32'(pop), 32'h2);
        step();
        pop_req = 1'b0;
        grand   = 4'b0000;
        chk("s1_busy_t1", 32'(busy), 32'h1);
        chk("s1_push_t1", 32'(push), 32'h0);
        step();
        chk("s1_push", 32'(push), 32'h1);
        chk("s1_dout", 32'(data_out), 32'hA);
        chk("s1_src",  32'(src_id), 32'h1);
        chk("s1_busy_t2", 32'(busy), 32'h1);
        step();
        chk("s1_push_end", 32'(push), 32'h0);
        chk("s1_busy_end", 32'(busy), 32'h0);

`ifdef VC_POP_CNT_EN
        // Five pops on ch3 saturate a 2-bit counter at 3.
        cnt_sel = 2'd3;
        pop_req = 1'b1;
        grand   = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            step();
        end
        pop_req = 1'b0;
        grand   = 4'b0000;
        step();
        step();
        chk("cnt_ch3_sat", 32'(cnt_out), 32'h3);
        cnt_sel = 2'd0;
        step();
        chk("cnt_ch0", 32'(cnt_out), 32'h0);
        cnt_sel = 2'd1;
        step();
        chk("cnt_ch1", 32'(cnt_out), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
